stream_producer: RTL

- Parametrised multi-channel transaction source for the pipelined stall/flush testbed; successor to the fixed two-channel producer.
- Each of NUM_CH channels emits a stream of (address, id) items under per-channel stall backpressure, with an optional transaction limit and a start/restart control.
- Flush pulses come from an external request port and/or a one-shot internal timer, with defined collision arbitration.

---
 rtl/stream_producer_if.sv | 30 +++
 rtl/stream_producer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/stream_producer_if.sv
// Stream/flush bundle between stream_producer and its consumer.
// master = producer side, slave = consumer side.
interface stream_producer_if #(
    parameter int NUM_CH   = 2,
    parameter int CH_IDX_W = 1,
    parameter int ADDR_W   = 32,
    parameter int ID_W     = 8
);
    logic                     start;
    logic [NUM_CH-1:0]        in_stall;
    logic [NUM_CH*ADDR_W-1:0] out_address;
    logic [NUM_CH*ID_W-1:0]   out_id;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        out_done;
    logic                     flush_req;
    logic [CH_IDX_W-1:0]      flush_req_ch;
    logic [ID_W-1:0]          flush_req_id;
    logic [NUM_CH-1:0]        flush;
    logic [NUM_CH*ID_W-1:0]   flush_id;

    modport master (
        input  start, in_stall, flush_req, flush_req_ch, flush_req_id,
        output out_address, out_id, out_valid, out_done, flush, flush_id
    );

    modport slave (
        output start, in_stall, flush_req, flush_req_ch, flush_req_id,
        input  out_address, out_id, out_valid, out_done, flush, flush_id
    );
endinterface

// File: rtl/stream_producer.sv
// Multi-channel (address, id) stream source with flush pulse generation.
// Optional one-shot flush timer enabled by defining FLUSH_TIMER_EN.
module stream_producer #(
    parameter int              NUM_CH      = 2,
    parameter int              CH_IDX_W    = 1,
    parameter int              ADDR_W      = 32,
    parameter int              ID_W        = 8,
    parameter int              SEQ_W       = 4,
    parameter int              STRIDE      = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int              NUM_TXN     = 0,
    parameter int              FLUSH_DELAY = 60,
    parameter int              FLUSH_CH    = 0,
    parameter logic [ID_W-1:0] FLUSH_ID    = ID_W'(8'h16)
) (
    input  logic             clk,
    input  logic             reset,
    stream_producer_if.master bus
);

    localparam int TAG_W = ID_W - SEQ_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [TAG_W-1:0] TAG = TAG_W'(c + 1);

        state_t            r_state;
        state_t            w_next;
        logic [ADDR_W-1:0] r_addr;
        logic [SEQ_W-1:0]  r_seq;
        logic [31:0]       r_cnt;
        logic              w_start;
        logic              w_acc;
        logic              w_last;
        logic              w_valid;
        logic              w_done;
        logic [ID_W-1:0]   w_id;

        assign w_start = bus.start && (r_state != S_RUN);
        assign w_acc   = (r_state == S_RUN) && !bus.in_stall[c];
        assign w_last  = (NUM_TXN != 0) && (r_cnt == 32'(NUM_TXN - 1));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) r_state <= S_IDLE;
            else       r_state <= w_next;
        end

        always_comb begin
            w_next = r_state;
            unique case (1'b1)
                w_start:           w_next = S_RUN;
                (w_acc && w_last): w_next = S_DONE;
                default:           ;
            endcase
        end

        always_comb begin
            w_valid = (r_state == S_RUN);
            w_done  = (r_state == S_DONE);
            w_id    = (r_state == S_IDLE) ? '0 : {TAG, r_seq};
        end

        // Last accepted item is held in place once the limit is reached
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_addr <= '0;
                r_seq  <= '0;
                r_cnt  <= '0;
            end else if (w_start) begin
                r_addr <= BASE_ADDR;
                r_seq  <= '0;
                r_cnt  <= '0;
            end else if (w_acc && !w_last) begin
                r_addr <= r_addr + ADDR_W'(STRIDE);
                r_seq  <= r_seq + SEQ_W'(1);
                r_cnt  <= r_cnt + 32'd1;
            end
        end

        assign bus.out_address[c*ADDR_W +: ADDR_W] = r_addr;
        assign bus.out_id[c*ID_W +: ID_W]          = w_id;
        assign bus.out_valid[c]                    = w_valid;
        assign bus.out_done[c]                     = w_done;
    end

    logic                   w_ext;
    logic                   w_tmr;
    logic [NUM_CH-1:0]      w_flush;
    logic [NUM_CH*ID_W-1:0] w_fid;
    logic [NUM_CH-1:0]      r_flush;
    logic [NUM_CH*ID_W-1:0] r_fid;

    assign w_ext = bus.flush_req && (32'(bus.flush_req_ch) < NUM_CH);

`ifdef FLUSH_TIMER_EN
    localparam int TMR_W = $clog2(FLUSH_DELAY + 2);

    logic [TMR_W-1:0] r_tmr;
    logic             r_issued;
    logic             r_pend;
    logic             w_due;

    assign w_due = (r_tmr == '0) && !r_issued;
    assign w_tmr = (w_due || r_pend) && !w_ext;

    // External requests win; a blocked timer flush waits as pending
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmr    <= TMR_W'(FLUSH_DELAY);
            r_issued <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            if (r_tmr != '0) r_tmr <= r_tmr - TMR_W'(1);
            if (w_tmr) begin
                r_issued <= 1'b1;
                r_pend   <= 1'b0;
            end else if (w_due && w_ext) begin
                r_pend   <= 1'b1;
            end
        end
    end
`else
    logic w_unused;
    assign w_unused = ^32'(FLUSH_DELAY);
    assign w_tmr    = 1'b0;
`endif

    always_comb begin
        w_flush = '0;
        w_fid   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_ext && (bus.flush_req_ch == CH_IDX_W'(c))) begin
                w_flush[c]             = 1'b1;
                w_fid[c*ID_W +: ID_W]  = bus.flush_req_id;
            end else if (w_tmr && (c == FLUSH_CH)) begin
                w_flush[c]             = 1'b1;
                w_fid[c*ID_W +: ID_W]  = FLUSH_ID;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flush <= '0;
            r_fid   <= '0;
        end else begin
            r_flush <= w_flush;
            r_fid   <= w_fid;
        end
    end

    assign bus.flush    = r_flush;
    assign bus.flush_id = r_fid;

endmodule
